// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the decode-stage sequencer: RV32I opcode constants,
// immediate-format selector encodings, result-source encodings, the packed
// control-bit bundle carried from ID into EX, and the NOP instruction word.
package decode_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_B    = 3'b001;
  localparam logic [2:0] IMM_J    = 3'b010;
  localparam logic [2:0] IMM_S    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_main_dec.sv
// main_dec: purely combinational opcode decoder.
//   opcode_i    [6:0] instruction opcode field
//   imm_sel_o   [2:0] immediate format for the immediate generator
//   ctrl_o      [7:0] packed ctrl_t control bundle
//   uses_rs1_o        instruction reads rs1
//   uses_rs2_o        instruction reads rs2
//   illegal_o         opcode outside the decoded set
module main_dec
  import decode_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_sel_o,
  output logic [7:0] ctrl_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       illegal_o
);

  ctrl_t ctrl;

  always_comb begin
    imm_sel_o  = IMM_NONE;
    ctrl       = '0;
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b0;
    illegal_o  = 1'b0;
    unique case (opcode_i)
      OPC_LUI, OPC_AUIPC: begin
        imm_sel_o      = IMM_U;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        uses_rs1_o     = 1'b0;
      end
      OPC_JAL: begin
        imm_sel_o       = IMM_J;
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        uses_rs1_o      = 1'b0;
      end
      OPC_JALR: begin
        imm_sel_o       = IMM_I;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OPC_BRANCH: begin
        imm_sel_o   = IMM_B;
        ctrl.branch = 1'b1;
        uses_rs2_o  = 1'b1;
      end
      OPC_LOAD: begin
        imm_sel_o       = IMM_I;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_LOAD;
      end
      OPC_STORE: begin
        imm_sel_o      = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rs2_o     = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_sel_o      = IMM_I;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_OP: begin
        imm_sel_o      = IMM_NONE;
        ctrl.reg_write = 1'b1;
        uses_rs2_o     = 1'b1;
      end
      default: begin
        // Illegal words read no registers so they can never trigger an interlock.
        illegal_o  = 1'b1;
        uses_rs1_o = 1'b0;
      end
    endcase
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: decode-stage sequencer for a 5-stage RV32I pipeline.
// Owns the IF/ID register and the ID/EX control register, decodes instrD,
// and arbitrates memory freeze > taken-branch flush > load-use interlock > advance.
//   clk, rst_n            clock, synchronous active-low reset
//   instrF, pcF           fetched instruction and its PC
//   memBusyM              data memory busy; freezes the whole pipeline
//   branchTakenE          taken branch/jump in EX; flushes D and E
//   instrD, pcD, validD   IF/ID contents
//   immSelD, illegalD     decode of instrD
//   stallF                hold PC/fetch
//   validE, rdE, *E       ID/EX contents
module decode_ctrl
  import decode_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrF,
  input  logic [31:0] pcF,
  input  logic        memBusyM,
  input  logic        branchTakenE,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic [2:0]  immSelD,
  output logic        illegalD,
  output logic        stallF,
  output logic        validE,
  output logic [4:0]  rdE,
  output logic        regWriteE,
  output logic        memReadE,
  output logic        memWriteE,
  output logic        aluSrcE,
  output logic        branchE,
  output logic        jumpE,
  output logic [1:0]  resultSrcE,
  output logic        illegalE
);

  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pcD_q, pcD_d;
  logic        validD_q, validD_d;
  logic        validE_q, validE_d;
  logic [4:0]  rdE_q, rdE_d;
  ctrl_t       ctrlE_q, ctrlE_d;
  logic        illegalE_q, illegalE_d;

  logic [2:0]  dec_imm_sel;
  logic [7:0]  dec_ctrl_raw;
  ctrl_t       dec_ctrl;
  ctrl_t       ctrl_live;
  logic        uses_rs1, uses_rs2, dec_illegal;
  logic        luh;

  main_dec u_main_dec (
    .opcode_i   (instrD_q[6:0]),
    .imm_sel_o  (dec_imm_sel),
    .ctrl_o     (dec_ctrl_raw),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2),
    .illegal_o  (dec_illegal)
  );

  assign dec_ctrl = ctrl_t'(dec_ctrl_raw);

  always_comb begin
    ctrl_live = '0;
    if (validD_q && !dec_illegal) ctrl_live = dec_ctrl;
  end

  assign immSelD  = validD_q ? dec_imm_sel : IMM_NONE;
  assign illegalD = validD_q & dec_illegal;

  assign luh = validD_q & validE_q & ctrlE_q.mem_read & (rdE_q != 5'd0) &
               ((uses_rs1 & (rdE_q == instrD_q[19:15])) |
                (uses_rs2 & (rdE_q == instrD_q[24:20])));

  assign stallF = memBusyM | (~branchTakenE & luh);

  always_comb begin
    instrD_d   = instrD_q;
    pcD_d      = pcD_q;
    validD_d   = validD_q;
    validE_d   = validE_q;
    rdE_d      = rdE_q;
    ctrlE_d    = ctrlE_q;
    illegalE_d = illegalE_q;
    if (memBusyM) begin
      // whole pipeline frozen: hold everything
    end else if (branchTakenE) begin
      // wrong-path instruction in D is discarded; any interlock it raised is moot
      instrD_d   = NOP_INSTR;
      pcD_d      = 32'd0;
      validD_d   = 1'b0;
      validE_d   = 1'b0;
      rdE_d      = 5'd0;
      ctrlE_d    = '0;
      illegalE_d = 1'b0;
    end else if (luh) begin
      // dependent instruction waits one cycle in D; EX gets a bubble
      validE_d   = 1'b0;
      rdE_d      = 5'd0;
      ctrlE_d    = '0;
      illegalE_d = 1'b0;
    end else begin
      instrD_d   = instrF;
      pcD_d      = pcF;
      validD_d   = 1'b1;
      validE_d   = validD_q;
      rdE_d      = instrD_q[11:7];
      ctrlE_d    = ctrl_live;
      illegalE_d = illegalD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instrD_q   <= NOP_INSTR;
      pcD_q      <= 32'd0;
      validD_q   <= 1'b0;
      validE_q   <= 1'b0;
      rdE_q      <= 5'd0;
      ctrlE_q    <= '0;
      illegalE_q <= 1'b0;
    end else begin
      instrD_q   <= instrD_d;
      pcD_q      <= pcD_d;
      validD_q   <= validD_d;
      validE_q   <= validE_d;
      rdE_q      <= rdE_d;
      ctrlE_q    <= ctrlE_d;
      illegalE_q <= illegalE_d;
    end
  end

  assign instrD     = instrD_q;
  assign pcD        = pcD_q;
  assign validD     = validD_q;
  assign validE     = validE_q;
  assign rdE        = rdE_q;
  assign regWriteE  = ctrlE_q.reg_write;
  assign memReadE   = ctrlE_q.mem_read;
  assign memWriteE  = ctrlE_q.mem_write;
  assign aluSrcE    = ctrlE_q.alu_src;
  assign branchE    = ctrlE_q.branch;
  assign jumpE      = ctrlE_q.jump;
  assign resultSrcE = ctrlE_q.result_src;
  assign illegalE   = illegalE_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: the driver advances a behavioural pipeline
// model and queues the expected visible state for each cycle; the monitor pops
// and compares every cycle.
module tb_decode_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instrF, pcF;
  logic        memBusyM, branchTakenE;
  logic [31:0] instrD, pcD;
  logic        validD, illegalD, stallF, validE;
  logic [2:0]  immSelD;
  logic [4:0]  rdE;
  logic        regWriteE, memReadE, memWriteE, aluSrcE, branchE, jumpE, illegalE;
  logic [1:0]  resultSrcE;

  decode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instrF(instrF), .pcF(pcF),
    .memBusyM(memBusyM), .branchTakenE(branchTakenE),
    .instrD(instrD), .pcD(pcD), .validD(validD), .immSelD(immSelD),
    .illegalD(illegalD), .stallF(stallF), .validE(validE), .rdE(rdE),
    .regWriteE(regWriteE), .memReadE(memReadE), .memWriteE(memWriteE),
    .aluSrcE(aluSrcE), .branchE(branchE), .jumpE(jumpE),
    .resultSrcE(resultSrcE), .illegalE(illegalE)
  );

  always #5 clk = ~clk;

  // ctrl bits ordered {regWrite, memRead, memWrite, aluSrc, branch, jump, resultSrc[1:0]}
  typedef struct packed {
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic [2:0]  imm_sel;
    logic        ill_d;
    logic        stall;
    logic        valid_e;
    logic [4:0]  rd_e;
    logic [7:0]  ctrl_e;
    logic        ill_e;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;
  string phase  = "init";

  // ---------------- reference model ----------------
  // Decode table: {immSel, ctrl8, usesRs1, usesRs2, illegal} straight from the opcode table.
  function automatic logic [13:0] ref_decode(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111: return {3'b100, 8'b1001_0000, 1'b0, 1'b0, 1'b0};
      7'b1101111:             return {3'b010, 8'b1000_0110, 1'b0, 1'b0, 1'b0};
      7'b1100111:             return {3'b000, 8'b1001_0110, 1'b1, 1'b0, 1'b0};
      7'b1100011:             return {3'b001, 8'b0000_1000, 1'b1, 1'b1, 1'b0};
      7'b0000011:             return {3'b000, 8'b1101_0001, 1'b1, 1'b0, 1'b0};
      7'b0100011:             return {3'b011, 8'b0011_0000, 1'b1, 1'b1, 1'b0};
      7'b0010011:             return {3'b000, 8'b1001_0000, 1'b1, 1'b0, 1'b0};
      7'b0110011:             return {3'b111, 8'b1000_0000, 1'b1, 1'b1, 1'b0};
      default:                return {3'b111, 8'b0000_0000, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction

  logic [31:0] m_instr, m_pc;
  logic        m_vd, m_ve, m_ille;
  logic [4:0]  m_rd;
  logic [7:0]  m_ctrl;
  bit          m_known = 0;

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1,
                                     input int rs2);
    logic [31:0] w;
    w = 32'h0;
    w[6:0]   = op;
    w[11:7]  = 5'(rd);
    w[19:15] = 5'(rs1);
    w[24:20] = 5'(rs2);
    return w;
  endfunction

  task automatic step(input logic rst, input logic [31:0] ins, input logic busy,
                      input logic bt);
    logic [13:0] dec;
    logic [7:0]  live;
    logic        ill, hz;
    obs_t        e;
    @(negedge clk);
    rst_n = rst; instrF = ins; pcF = pcF + 32'd4; memBusyM = busy; branchTakenE = bt;
    dec  = ref_decode(m_instr[6:0]);
    ill  = m_vd & dec[0];
    live = (m_vd && !dec[0]) ? dec[10:3] : 8'h00;
    hz   = m_vd && m_ve && m_ctrl[6] && m_rd != 0 &&
           ((dec[2] && m_rd == m_instr[19:15]) || (dec[1] && m_rd == m_instr[24:20]));
    if (m_known) begin
      e.instr_d = m_instr; e.pc_d = m_pc; e.valid_d = m_vd;
      e.imm_sel = m_vd ? dec[13:11] : 3'b111;
      e.ill_d   = ill;
      e.stall   = busy | (!bt & hz);
      e.valid_e = m_ve; e.rd_e = m_rd; e.ctrl_e = m_ctrl; e.ill_e = m_ille;
      exp_q.push_back(e);
      tag_q.push_back(phase);
    end
    if (!rst) begin
      m_instr = NOP; m_pc = 0; m_vd = 0; m_ve = 0; m_rd = 0; m_ctrl = 0; m_ille = 0;
      m_known = 1;
    end else if (busy) begin
    end else if (bt) begin
      m_instr = NOP; m_pc = 0; m_vd = 0; m_ve = 0; m_rd = 0; m_ctrl = 0; m_ille = 0;
    end else if (hz) begin
      m_ve = 0; m_rd = 0; m_ctrl = 0; m_ille = 0;
    end else begin
      m_ve = m_vd; m_rd = m_instr[11:7]; m_ctrl = live; m_ille = ill;
      m_instr = ins; m_pc = pcF; m_vd = 1;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    obs_t  a, e;
    string t;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a.instr_d = instrD; a.pc_d = pcD; a.valid_d = validD; a.imm_sel = immSelD;
        a.ill_d = illegalD; a.stall = stallF; a.valid_e = validE; a.rd_e = rdE;
        a.ctrl_e = {regWriteE, memReadE, memWriteE, aluSrcE, branchE, jumpE, resultSrcE};
        a.ill_e = illegalE;
        n_vec++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got instrD=%h pcD=%h vD=%b imm=%b illD=%b stallF=%b vE=%b rdE=%0d ctrlE=%b illE=%b | exp instrD=%h pcD=%h vD=%b imm=%b illD=%b stallF=%b vE=%b rdE=%0d ctrlE=%b illE=%b",
                   t, $time, a.instr_d, a.pc_d, a.valid_d, a.imm_sel, a.ill_d, a.stall,
                   a.valid_e, a.rd_e, a.ctrl_e, a.ill_e, e.instr_d, e.pc_d, e.valid_d,
                   e.imm_sel, e.ill_d, e.stall, e.valid_e, e.rd_e, e.ctrl_e, e.ill_e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] lw5, add6, lw0, add_0;
  logic [6:0]  sweep_ops[8];

  initial begin
    rst_n = 1'b0; instrF = NOP; pcF = 32'h0000_1000; memBusyM = 1'b0; branchTakenE = 1'b0;
    lw5   = mk(7'b0000011, 5, 1, 0);
    add6  = mk(7'b0110011, 6, 5, 2);
    lw0   = mk(7'b0000011, 0, 1, 0);
    add_0 = mk(7'b0110011, 6, 0, 2);

    phase = "reset";
    step(0, $urandom, 0, 0);
    step(0, $urandom, 0, 0);
    step(1, NOP, 0, 0);

    phase = "load_use";
    step(1, lw5, 0, 0); step(1, add6, 0, 0);
    for (int i = 0; i < 4; i++) step(1, NOP, 0, 0);
    phase = "load_use_x0";
    step(1, lw0, 0, 0); step(1, add_0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, NOP, 0, 0);

    phase = "flush_vs_luh";
    step(1, lw5, 0, 0); step(1, add6, 0, 0);
    step(1, NOP, 0, 1);
    for (int i = 0; i < 3; i++) step(1, NOP, 0, 0);

    phase = "busy_luh";
    step(1, lw5, 0, 0); step(1, add6, 0, 0);
    for (int i = 0; i < 3; i++) step(1, NOP, 1, 0);
    for (int i = 0; i < 4; i++) step(1, NOP, 0, 0);

    phase = "sweep";
    sweep_ops = '{7'b0110111, 7'b1101111, 7'b1100111, 7'b1100011,
                  7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};
    for (int i = 0; i < 8; i++) begin
      step(1, mk(sweep_ops[i], 7, 3, 4), 0, 0);
      step(1, NOP, 0, 0);
      step(1, NOP, 0, 0);
    end

    phase = "reset_mid_stall";
    step(1, lw5, 0, 0); step(1, add6, 0, 0);
    step(1, NOP, 1, 0);
    step(0, $urandom, 1, 0);
    step(1, NOP, 0, 0);
    step(1, NOP, 0, 0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      logic [6:0]  ops[10];
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
      w = $urandom;
      w[6:0]   = ($urandom_range(0, 2) == 0) ? 7'b0000011 : ops[$urandom_range(0, 9)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 49) != 0), w, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 11) == 0));
    end

    phase = "drain";
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
